tone_generator: RTL and testbench

TONE_GENERATOR -- requirements
Module: tone_generator

---
 rtl/tone_pkg.sv | 14 +
 rtl/half_period_counter.sv | 38 +++
 rtl/tone_generator.sv | 141 ++++++++++++++
 tb/tb_tone_generator.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/tone_pkg.sv
// tone_pkg: shared constants and types for the tone generator.
//   PERIOD_W         default width of half-period counts (clk cycles)
//   MIN_HALF_PERIOD  default minimum playable half-period; smaller loads mean silence
//   tone_state_t     IDLE / PLAY / DRAIN state encoding
package tone_pkg;
   localparam int PERIOD_W = 20;
   localparam logic [PERIOD_W-1:0] MIN_HALF_PERIOD = 20'd16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PLAY  = 2'd1,
      ST_DRAIN = 2'd2
   } tone_state_t;
endpackage

// File: rtl/half_period_counter.sv
// half_period_counter: down-counter with clear, reload and terminal-count flag.
//   clk, reset   rising-edge clock, async active-high reset
//   clr          force count to 0 (highest priority)
//   reload       load reload_val on this edge
//   reload_val   value loaded on reload
//   count        current count
//   tc           terminal count, high while count == 0
module half_period_counter #(
   parameter int W = 20
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         reload,
   input  logic [W-1:0] reload_val,
   output logic [W-1:0] count,
   output logic         tc
);
   localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

   logic [W-1:0] count_q, count_d;

   // Decrement is gated at zero so the counter can never wrap.
   always_comb begin
      count_d = count_q;
      if (clr)                 count_d = '0;
      else if (reload)         count_d = reload_val;
      else if (count_q != '0)  count_d = count_q - ONE;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) count_q <= '0;
      else       count_q <= count_d;
   end

   assign count = count_q;
   assign tc    = (count_q == '0);
endmodule

// File: rtl/tone_generator.sv
// tone_generator: square-wave note player with glitch-free period changes.
//   clk, reset     rising-edge clock, async active-high reset
//   half_period    note half-period in clk cycles, sampled on load
//   load           one-cycle strobe, start/update note
//   stop           one-cycle strobe, key released
//   tone_out       registered square wave
//   playing        high whenever not IDLE
//   active_period  half-period currently being counted (0 in IDLE)
import tone_pkg::*;

module tone_generator #(
   parameter int                    PERIOD_W        = tone_pkg::PERIOD_W,
   parameter logic [PERIOD_W-1:0]   MIN_HALF_PERIOD = tone_pkg::MIN_HALF_PERIOD
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [PERIOD_W-1:0] half_period,
   input  logic                load,
   input  logic                stop,
   output logic                tone_out,
   output logic                playing,
   output logic [PERIOD_W-1:0] active_period
);
   localparam logic [PERIOD_W-1:0] ONE = {{(PERIOD_W-1){1'b0}}, 1'b1};

   tone_state_t         state_q, state_d;
   logic                tone_q, tone_d;
   logic [PERIOD_W-1:0] active_q, active_d;
   logic [PERIOD_W-1:0] pend_q, pend_d;
   logic                pend_vld_q, pend_vld_d;

   logic                cnt_clr, cnt_reload, cnt_tc;
   logic [PERIOD_W-1:0] cnt_val, cnt;
   logic                load_ok, stop_eff;
   logic [PERIOD_W-1:0] next_per;

   // A too-short load means silence, so it behaves like stop; stop beats a same-cycle load.
   assign load_ok  = load & (half_period >= MIN_HALF_PERIOD) & ~stop;
   assign stop_eff = stop | (load & (half_period < MIN_HALF_PERIOD));
   // Period for the next level: a same-cycle load wins over an older pending value.
   assign next_per = load_ok ? half_period : (pend_vld_q ? pend_q : active_q);

   always_comb begin
      state_d    = state_q;
      tone_d     = tone_q;
      active_d   = active_q;
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
      cnt_clr    = 1'b0;
      cnt_reload = 1'b0;
      cnt_val    = next_per - ONE;

      case (state_q)
         ST_IDLE: begin
            if (load_ok) begin
               state_d    = ST_PLAY;
               tone_d     = 1'b1;
               active_d   = half_period;
               cnt_reload = 1'b1;
            end
         end
         ST_PLAY: begin
            if (stop_eff && (!tone_q || cnt_tc)) begin
               // Low phase, or the last cycle of the high phase: no drain needed.
               state_d    = ST_IDLE;
               tone_d     = 1'b0;
               active_d   = '0;
               pend_vld_d = 1'b0;
               cnt_clr    = 1'b1;
            end else if (stop_eff) begin
               state_d = ST_DRAIN;
            end else if (cnt_tc) begin
               tone_d     = ~tone_q;
               active_d   = next_per;
               pend_vld_d = 1'b0;
               cnt_reload = 1'b1;
            end else if (load_ok) begin
               pend_d     = half_period;
               pend_vld_d = 1'b1;
            end
         end
         ST_DRAIN: begin
            if (load_ok) begin
               state_d = ST_PLAY;
               if (cnt_tc) begin
                  tone_d     = ~tone_q;
                  active_d   = next_per;
                  pend_vld_d = 1'b0;
                  cnt_reload = 1'b1;
               end else begin
                  pend_d     = half_period;
                  pend_vld_d = 1'b1;
               end
            end else if (cnt_tc) begin
               state_d    = ST_IDLE;
               tone_d     = 1'b0;
               active_d   = '0;
               pend_vld_d = 1'b0;
               cnt_clr    = 1'b1;
            end
         end
         default: begin
            state_d    = ST_IDLE;
            tone_d     = 1'b0;
            active_d   = '0;
            pend_vld_d = 1'b0;
            cnt_clr    = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         tone_q     <= 1'b0;
         active_q   <= '0;
         pend_q     <= '0;
         pend_vld_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         tone_q     <= tone_d;
         active_q   <= active_d;
         pend_q     <= pend_d;
         pend_vld_q <= pend_vld_d;
      end
   end

   half_period_counter #(.W(PERIOD_W)) u_cnt (
      .clk        (clk),
      .reset      (reset),
      .clr        (cnt_clr),
      .reload     (cnt_reload),
      .reload_val (cnt_val),
      .count      (cnt),
      .tc         (cnt_tc)
   );

   assign tone_out      = tone_q;
   assign playing       = (state_q != ST_IDLE);
   assign active_period = active_q;
endmodule

// File: tb/tb_tone_generator.sv
module tb_tone_generator;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [19:0] half_period = '0;
   logic        load = 1'b0;
   logic        stop = 1'b0;
   logic        tone_out;
   logic        playing;
   logic [19:0] active_period;

   int errors = 0;
   int checks = 0;

   tone_generator dut (
      .clk           (clk),
      .reset         (reset),
      .half_period   (half_period),
      .load          (load),
      .stop          (stop),
      .tone_out      (tone_out),
      .playing       (playing),
      .active_period (active_period)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance one clock; returns at the following falling edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic pulse_load(input logic [19:0] hp);
      half_period = hp;
      load = 1'b1;
      step();
      load = 1'b0;
   endtask

   task automatic pulse_stop();
      stop = 1'b1;
      step();
      stop = 1'b0;
   endtask

   // Number of cycles tone_out keeps its present value (bounded).
   task automatic run_len(output int n);
      logic v;
      v = tone_out;
      n = 0;
      while (tone_out === v && n < 200) begin
         n++;
         step();
      end
   endtask

   initial begin
      int n;
      int toggles;
      logic prev;

      // Reset state
      @(negedge clk);
      chk("rst_tone", tone_out, 0);
      chk("rst_playing", playing, 0);
      chk("rst_active", active_period, 0);
      step();
      reset = 1'b0;

      // Basic 16-cycle note, first load right after reset
      pulse_load(20'd16);
      chk("p16_tone_start", tone_out, 1);
      chk("p16_playing", playing, 1);
      chk("p16_active", active_period, 16);
      run_len(n); chk("p16_high", n, 16);
      run_len(n); chk("p16_low", n, 16);
      chk("p16_playing_low_end", playing, 1);

      // Now in cycle 1 of a high phase: load 32 during its 4th cycle
      step(); step(); step();
      pulse_load(20'd32);
      chk("p32_active_pending", active_period, 16);
      run_len(n); chk("p32_first_high_total", n + 4, 16);
      chk("p32_active", active_period, 32);
      run_len(n); chk("p32_low", n, 32);
      run_len(n); chk("p32_high", n, 32);

      // Stop during low phase: immediate return to IDLE
      chk("p32_tone_low", tone_out, 0);
      pulse_stop();
      chk("stop_low_playing", playing, 0);
      chk("stop_low_active", active_period, 0);
      chk("stop_low_tone", tone_out, 0);

      // Stop in the 5th cycle of a 16-cycle high phase: drain the full high
      pulse_load(20'd16);
      step(); step(); step(); step();
      pulse_stop();
      chk("drain_playing", playing, 1);
      chk("drain_tone", tone_out, 1);
      run_len(n); chk("drain_high_total", n + 5, 16);
      chk("drain_end_playing", playing, 0);
      chk("drain_end_active", active_period, 0);
      toggles = 0;
      prev = tone_out;
      for (int i = 0; i < 40; i++) begin
         step();
         if (tone_out !== prev) toggles++;
         prev = tone_out;
      end
      chk("drain_no_toggles", toggles, 0);

      // IDLE: load+stop together, then a too-short load
      half_period = 20'd16;
      load = 1'b1;
      stop = 1'b1;
      step();
      load = 1'b0;
      stop = 1'b0;
      chk("ls_tone", tone_out, 0);
      chk("ls_playing", playing, 0);
      pulse_load(20'd8);
      chk("short_tone", tone_out, 0);
      chk("short_playing", playing, 0);
      step(); step();
      chk("short_active", active_period, 0);

      // Async reset in the middle of a high phase
      pulse_load(20'd16);
      step(); step(); step(); step();
      #2 reset = 1'b1;
      #1;
      chk("areset_tone", tone_out, 0);
      chk("areset_playing", playing, 0);
      chk("areset_active", active_period, 0);
      @(negedge clk);
      reset = 1'b0;
      pulse_load(20'd16);
      chk("post_rst_tone", tone_out, 1);
      run_len(n); chk("post_rst_high", n, 16);
      run_len(n); chk("post_rst_low", n, 16);

      // Return to IDLE via reset, then DRAIN -> PLAY by a 24-cycle load
      #2 reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      pulse_load(20'd16);
      step(); step();
      pulse_stop();
      chk("d2p_draining", playing, 1);
      step(); step();
      pulse_load(20'd24);
      run_len(n); chk("d2p_high_total", n + 6, 16);
      chk("d2p_playing", playing, 1);
      chk("d2p_active", active_period, 24);
      run_len(n); chk("d2p_low", n, 24);
      run_len(n); chk("d2p_high", n, 24);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
